// File: rtl/iq_fetch_stage_if.sv
// Shared fetch/queue types and the fetch-side bus bundle
// (I-cache read port, queue enqueue port, flush redirect).
package iq_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } pci_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } flush_t;

endpackage

interface iq_fetch_if;
  import iq_fetch_pkg::*;

  logic        icache_read;
  logic [31:0] icache_addr;
  logic        icache_resp_valid;
  logic [63:0] icache_rdata;
  logic        iq_enq;
  pci_t        iq_in;
  pci_t        iq_in1;
  logic        iq_num_enq;
  logic        iq_full;
  flush_t      flush;

  modport master (
    output icache_read,
    output icache_addr,
    input  icache_resp_valid,
    input  icache_rdata,
    output iq_enq,
    output iq_in,
    output iq_in1,
    output iq_num_enq,
    input  iq_full,
    input  flush
  );

  modport slave (
    input  icache_read,
    input  icache_addr,
    output icache_resp_valid,
    output icache_rdata,
    input  iq_enq,
    input  iq_in,
    input  iq_in1,
    input  iq_num_enq,
    output iq_full,
    output flush
  );

endinterface

// File: rtl/iq_fetch_stage.sv
// Fetch stage feeding the instruction queue: one 64-bit line read in flight.
// Optional perf counters are built when IQ_FETCH_PERF_EN is defined.
module iq_fetch_stage
  import iq_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  iq_fetch_if.master  fif
`ifdef IQ_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int unsigned LINE_BYTES = 8;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] hold_q, hold_d;
  logic        read_q, read_d;

  logic        enq;
  logic [63:0] src;
  logic [31:0] line_next;
  logic [31:0] instr0;
  pci_t        e0, e1;

  assign line_next = {pc_q[31:3], 3'b000} + 32'(LINE_BYTES);

  // Next-state, pc advance, hold capture and enqueue decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    enq     = 1'b0;
    src     = fif.icache_rdata;
    unique case (state_q)
      REQ: state_d = WAIT;
      WAIT: begin
        if (fif.icache_resp_valid) begin
          if (fif.iq_full) begin
            hold_d  = fif.icache_rdata;
            state_d = HOLD;
          end else begin
            enq     = 1'b1;
            pc_d    = line_next;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        src = hold_q;
        if (!fif.iq_full) begin
          enq     = 1'b1;
          hold_d  = '0;
          pc_d    = line_next;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (fif.icache_resp_valid) state_d = REQ;
      end
    endcase
    // A read already in flight must be drained before a new one goes out.
    if (fif.flush.valid) begin
      pc_d   = fif.flush.pc;
      enq    = 1'b0;
      hold_d = '0;
      if ((state_q == WAIT || state_q == DRAIN) &&
          !fif.icache_resp_valid)
        state_d = DRAIN;
      else
        state_d = REQ;
    end
    read_d = (state_d != HOLD);
  end

  // Fetch state, pc, hold buffer and registered read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      read_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      read_q  <= read_d;
    end
  end

  // Pack the line into one or two queue entries based on pc[2].
  always_comb begin
    instr0    = pc_q[2] ? src[63:32] : src[31:0];
    e0        = '0;
    e0.pc     = pc_q;
    e0.instr  = instr0;
    e0.opcode = instr0[6:0];
    e1        = '0;
    e1.pc     = pc_q + 32'd4;
    e1.instr  = src[63:32];
    e1.opcode = src[38:32];
  end

  assign fif.icache_read = read_q;
  assign fif.icache_addr = {pc_q[31:3], 3'b000};
  assign fif.iq_enq      = enq;
  assign fif.iq_in       = e0;
  assign fif.iq_in1      = e1;
  assign fif.iq_num_enq  = enq & ~pc_q[2];

`ifdef IQ_FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flushc_q, flushc_d;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [1:0]  inc
  );
    logic [32:0] s;
    s = {1'b0, a} + 33'(inc);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Saturating event counts.
  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    flushc_d  = flushc_q;
    if (enq)
      fetched_d = sat_add(fetched_q, pc_q[2] ? 2'd1 : 2'd2);
    if (state_q == HOLD)
      stall_d = sat_add(stall_q, 2'd1);
    if (fif.flush.valid)
      flushc_d = sat_add(flushc_q, 2'd1);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flushc_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
      flushc_q  <= flushc_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
  assign perf_flush   = flushc_q;
`endif

endmodule
